stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 100, count-enable rate in Hz; DIV = CLK_HZ/TICK_HZ SHALL be an integer >= 2.
REQ-003 Parameter DB_CYCLES, default 1_000_000, cycles a synchronized button must be stable before it is accepted (10 ms).
REQ-004 clk_100MHz  in  1  sole clock; all logic SHALL be rising-edge clocked on it.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 btn_start  in  1  raw start button, asynchronous, active-high.
REQ-007 btn_stop  in  1  raw stop button.
REQ-008 btn_clear  in  1  raw clear button.
REQ-009 btn_lap  in  1  raw lap button.
REQ-010 cnt_en  out  1  one-cycle pulse; the time-counter datapath advances one 1/100 s.
REQ-011 cnt_clr  out  1  one-cycle pulse; the datapath zeroes all counters.
REQ-012 lap_load  out  1  one-cycle pulse; the datapath copies the live count into its lap register.
REQ-013 lap_freeze  out  1  level; display shows the lap register instead of the live count.
REQ-014 state  out  2  current FSM state: IDLE=00, RUN=01, PAUSE=10, LAP=11.

Function
REQ-015 Each button SHALL pass through a 2-FF synchronizer, then a debouncer that updates its output only after DB_CYCLES consecutive equal samples.
REQ-016 A rising edge of a debounced button SHALL produce a one-cycle event, asserted at most DB_CYCLES+4 cycles after the raw input settles high; holding a button SHALL produce exactly one event.
REQ-017 Prescaler SHALL count 0..DIV-1 and wrap; it SHALL be forced to 0 on the cycle the FSM leaves IDLE or PAUSE for RUN, so the first cnt_en arrives exactly DIV cycles after the state becomes RUN.
REQ-018 cnt_en SHALL pulse on the prescaler wrap cycle only while state is RUN or LAP; never in IDLE or PAUSE.
REQ-019 Transitions: IDLE --start--> RUN; RUN --stop--> PAUSE; RUN --lap--> LAP; LAP --lap--> RUN; LAP --stop--> PAUSE; PAUSE --start--> RUN; PAUSE --clear--> IDLE; IDLE --clear--> IDLE.
REQ-020 Any event not listed for the current state SHALL be ignored (clear in RUN/LAP, start in RUN/LAP, stop in IDLE/PAUSE, lap outside RUN/LAP).
REQ-021 Simultaneous events in one cycle SHALL resolve by priority stop > clear > start > lap; lower-priority events that cycle are discarded.
REQ-022 cnt_clr SHALL pulse for one cycle, registered, on every accepted clear event.
REQ-023 lap_load SHALL pulse for one cycle on the RUN->LAP transition; lap_freeze SHALL be high exactly while state is LAP.
REQ-024 All outputs SHALL be registered; outputs change the cycle after the triggering event.

Reset
REQ-025 reset_n low SHALL asynchronously force: state=IDLE, cnt_en=0, cnt_clr=0, lap_load=0, lap_freeze=0, prescaler=0, synchronizers, debouncers and edge detectors=0.
REQ-026 reset_n deassertion mid-press SHALL not generate an event until the button is released and pressed again after being debounced low.

Configuration
REQ-027 Macro STOPWATCH_LAP_EN: defined -> LAP state, lap_load and lap_freeze behave as above.
REQ-028 Without STOPWATCH_LAP_EN: btn_lap logic is not built, LAP state is unreachable, lap_load and lap_freeze are tied 0, all other behaviour unchanged.

Verification (CLK_HZ=1000, TICK_HZ=100 -> DIV=10, DB_CYCLES=4)
REQ-029 Reset, press start 20 cycles -> state=01 within 8 cycles; first cnt_en 10 cycles later, then every 10 cycles; 100 ticks counted in 1000 cycles.
REQ-030 RUN, press stop -> state=10, no cnt_en thereafter; press clear -> one cnt_clr pulse, state=00.
REQ-031 RUN, press lap -> one lap_load pulse, lap_freeze=1, cnt_en continues every 10 cycles; lap again -> lap_freeze=0, state=01.
REQ-032 Start and stop asserted same cycle while RUN -> state=10; clear pressed in RUN -> no cnt_clr, state stays 01.
REQ-033 Button bouncing 1-0-1 at 2-cycle intervals then held 50 cycles -> exactly one event; reset_n pulsed low mid-RUN -> all outputs 0, state=00 immediately.
REQ-034 Build without STOPWATCH_LAP_EN, press lap in RUN -> lap_load and lap_freeze stay 0, state stays 01.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button conditioning, run/pause/lap control FSM and the
// 1/100 s tick prescaler for a stopwatch datapath.
// Optional lap feature: define STOPWATCH_LAP_EN to build the LAP state,
// lap_load and lap_freeze. Without it those outputs are tied low.
//
// Output interface: cnt_en, cnt_clr and lap_load are single-cycle strobes
// with no back-pressure (the datapath must act on every strobe it sees);
// lap_freeze is a level. All outputs come straight from flops and change on
// the clock edge after the button event that causes them.
module stopwatch_ctrl #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       lap_load,
    output logic       lap_freeze,
    output logic [1:0] state
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int CW  = $clog2(DB_CYCLES + 1);

`ifdef STOPWATCH_LAP_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_LAP   = 2'b11
    } state_t;

    // Button bit order: 0=start, 1=stop, 2=clear, 3=lap (lap only when built).
    logic [NB-1:0] raw;
    logic [NB-1:0] sync1;
    logic [NB-1:0] sync2;
    logic [NB-1:0] cand;     // value currently being qualified
    logic [NB-1:0] db;       // debounced level
    logic [NB-1:0] db_prev;  // edge detector history
    logic [NB-1:0] armed;    // set once a stable low has been seen
    logic [NB-1:0] ev;
    logic [CW-1:0] db_cnt [NB];

`ifdef STOPWATCH_LAP_EN
    assign raw = {btn_lap, btn_clear, btn_stop, btn_start};
`else
    logic unused_lap;
    assign unused_lap = btn_lap;
    assign raw = {btn_clear, btn_stop, btn_start};
`endif

    // Two-flop synchronizer for every raw button.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debouncer: the output takes a new value only after DB_CYCLES equal
    // consecutive samples. A button is armed only after a qualified low, so a
    // press held across reset release never produces an event.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            cand    <= '0;
            db      <= '0;
            db_prev <= '0;
            armed   <= '0;
            for (int i = 0; i < NB; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            db_prev <= db;
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] != cand[i]) begin
                    cand[i]   <= sync2[i];
                    db_cnt[i] <= CW'(1);
                end else if (db_cnt[i] != CW'(DB_CYCLES)) begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                    if (db_cnt[i] == CW'(DB_CYCLES - 1)) begin
                        db[i] <= cand[i];
                        if (!cand[i]) begin
                            armed[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign ev = db & ~db_prev & armed;

    logic ev_start;
    logic ev_stop;
    logic ev_clear;
    logic ev_lap;

    assign ev_start = ev[0];
    assign ev_stop  = ev[1];
    assign ev_clear = ev[2];
`ifdef STOPWATCH_LAP_EN
    assign ev_lap   = ev[3];
`else
    assign ev_lap   = 1'b0;
`endif

    state_t        cur;
    state_t        nxt;
    logic          clr_nxt;
    logic          load_nxt;
    logic          en_nxt;
    logic          enter_run;
    logic          wrap;
    logic [PW-1:0] presc;

    assign state     = cur;
    assign wrap      = (presc == PW'(DIV - 1));
    assign enter_run = (nxt == S_RUN) && (cur == S_IDLE || cur == S_PAUSE);

    // Next-state logic: only the highest-priority event of the cycle
    // (stop > clear > start > lap) is considered; the rest are dropped.
    always_comb begin
        nxt      = cur;
        clr_nxt  = 1'b0;
        load_nxt = 1'b0;
        if (ev_stop) begin
            if (cur == S_RUN || cur == S_LAP) begin
                nxt = S_PAUSE;
            end
        end else if (ev_clear) begin
            if (cur == S_IDLE || cur == S_PAUSE) begin
                nxt     = S_IDLE;
                clr_nxt = 1'b1;
            end
        end else if (ev_start) begin
            if (cur == S_IDLE || cur == S_PAUSE) begin
                nxt = S_RUN;
            end
        end else if (ev_lap) begin
            if (cur == S_RUN) begin
                nxt      = S_LAP;
                load_nxt = 1'b1;
            end else if (cur == S_LAP) begin
                nxt = S_RUN;
            end
        end
        // A tick is only issued when counting both before and after this
        // edge, so leaving RUN never leaks a tick and entering RUN waits DIV.
        en_nxt = wrap && (cur == S_RUN || cur == S_LAP)
                      && (nxt == S_RUN || nxt == S_LAP);
    end

    // Prescaler: free-running 0..DIV-1, restarted on every entry into RUN.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
        end else if (enter_run || wrap) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // State register and registered control strobes.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            cur     <= S_IDLE;
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b0;
        end else begin
            cur     <= nxt;
            cnt_en  <= en_nxt;
            cnt_clr <= clr_nxt;
        end
    end

`ifdef STOPWATCH_LAP_EN
    // Lap strobe on RUN->LAP; freeze level follows the LAP state exactly.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            lap_load   <= 1'b0;
            lap_freeze <= 1'b0;
        end else begin
            lap_load   <= load_nxt;
            lap_freeze <= (nxt == S_LAP);
        end
    end
`else
    logic unused_load;
    assign unused_load = load_nxt;
    assign lap_load    = 1'b0;
    assign lap_freeze  = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl with CLK_HZ=1000, TICK_HZ=100 (DIV=10) and
// DB_CYCLES=4. Lap-specific vectors are selected by STOPWATCH_LAP_EN.
module tb_stopwatch_ctrl;

    logic       clk_100MHz = 1'b0;
    logic       reset_n    = 1'b1;
    logic       btn_start  = 1'b0;
    logic       btn_stop   = 1'b0;
    logic       btn_clear  = 1'b0;
    logic       btn_lap    = 1'b0;
    logic       cnt_en;
    logic       cnt_clr;
    logic       lap_load;
    logic       lap_freeze;
    logic [1:0] state;

    stopwatch_ctrl #(
        .CLK_HZ   (1000),
        .TICK_HZ  (100),
        .DB_CYCLES(4)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset_n   (reset_n),
        .btn_start (btn_start),
        .btn_stop  (btn_stop),
        .btn_clear (btn_clear),
        .btn_lap   (btn_lap),
        .cnt_en    (cnt_en),
        .cnt_clr   (cnt_clr),
        .lap_load  (lap_load),
        .lap_freeze(lap_freeze),
        .state     (state)
    );

    // ---------------- clock ----------------
    always #5 clk_100MHz = ~clk_100MHz;

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    int n_en      = 0;
    int n_clr     = 0;
    int n_load    = 0;
    int cyc_n     = 0;
    int last_en   = 0;
    bit en_valid  = 1'b0;
    int gap_bad   = 0;
    int viol_idle = 0;
    int viol_lap  = 0;

    // Pulse counting and running invariants, sampled on the falling edge.
    always @(negedge clk_100MHz) begin
        if (!reset_n) begin
            en_valid = 1'b0;
        end else begin
            cyc_n++;
            if (cnt_en)   n_en++;
            if (cnt_clr)  n_clr++;
            if (lap_load) n_load++;
            if (cnt_en && (state == 2'b00 || state == 2'b10)) viol_idle++;
            if (lap_freeze != (state == 2'b11)) viol_lap++;
`ifndef STOPWATCH_LAP_EN
            if (lap_load) viol_lap++;
`endif
            if (state == 2'b00 || state == 2'b10) begin
                en_valid = 1'b0;
            end else if (cnt_en) begin
                if (en_valid && (cyc_n - last_en) != 10) gap_bad++;
                last_en  = cyc_n;
                en_valid = 1'b1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    int hold_left = 0;

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
        if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) begin
                {btn_lap, btn_clear, btn_stop, btn_start} = 4'b0000;
            end
        end
    endtask

    // mask bits: 0=start 1=stop 2=clear 3=lap
    task automatic press(input logic [3:0] mask, input int hold);
        {btn_lap, btn_clear, btn_stop, btn_start} = mask;
        hold_left = hold;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_state"}, int'(state), 0);
        check({tag, "_en"},    int'(cnt_en), 0);
        check({tag, "_clr"},   int'(cnt_clr), 0);
        check({tag, "_load"},  int'(lap_load), 0);
        check({tag, "_frz"},   int'(lap_freeze), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] mask;
        logic [1:0] exp_state;
        int         exp_clr;
        int         exp_load;
        logic       exp_freeze;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [3:0] m, input logic [1:0] s,
                                input int c, input int l, input logic f);
        vec_t v;
        v.mask       = m;
        v.exp_state  = s;
        v.exp_clr    = c;
        v.exp_load   = l;
        v.exp_freeze = f;
        vecs.push_back(v);
    endfunction

    // ---------------- test ----------------
    initial begin
        int found;
        int base_en;
        int base_clr;
        int base_load;

        // Table: starts in RUN, ends in RUN.
        add(4'b0100, 2'b01, 0, 0, 1'b0);   // clear ignored in RUN
        add(4'b0001, 2'b01, 0, 0, 1'b0);   // start ignored in RUN
`ifdef STOPWATCH_LAP_EN
        add(4'b1000, 2'b11, 0, 1, 1'b1);   // RUN -> LAP, lap_load
        add(4'b0001, 2'b11, 0, 0, 1'b1);   // start ignored in LAP
        add(4'b0100, 2'b11, 0, 0, 1'b1);   // clear ignored in LAP
        add(4'b1000, 2'b01, 0, 0, 1'b0);   // LAP -> RUN
        add(4'b1000, 2'b11, 0, 1, 1'b1);   // RUN -> LAP again
        add(4'b0010, 2'b10, 0, 0, 1'b0);   // LAP -> PAUSE
        add(4'b0001, 2'b01, 0, 0, 1'b0);   // PAUSE -> RUN
        add(4'b1010, 2'b10, 0, 0, 1'b0);   // stop beats lap
        add(4'b0001, 2'b01, 0, 0, 1'b0);   // PAUSE -> RUN
`else
        add(4'b1000, 2'b01, 0, 0, 1'b0);   // lap has no effect
        add(4'b1000, 2'b01, 0, 0, 1'b0);   // still no effect
`endif
        add(4'b0010, 2'b10, 0, 0, 1'b0);   // RUN -> PAUSE
        add(4'b0010, 2'b10, 0, 0, 1'b0);   // stop ignored in PAUSE
        add(4'b1000, 2'b10, 0, 0, 1'b0);   // lap ignored in PAUSE
        add(4'b0001, 2'b01, 0, 0, 1'b0);   // PAUSE -> RUN
        add(4'b0011, 2'b10, 0, 0, 1'b0);   // start+stop: stop wins
        add(4'b0100, 2'b00, 1, 0, 1'b0);   // PAUSE -> IDLE, cnt_clr
        add(4'b0100, 2'b00, 1, 0, 1'b0);   // clear in IDLE, cnt_clr
        add(4'b0010, 2'b00, 0, 0, 1'b0);   // stop ignored in IDLE
        add(4'b1000, 2'b00, 0, 0, 1'b0);   // lap ignored in IDLE
        add(4'b0001, 2'b01, 0, 0, 1'b0);   // IDLE -> RUN
        add(4'b0010, 2'b10, 0, 0, 1'b0);   // RUN -> PAUSE
        add(4'b0101, 2'b00, 1, 0, 1'b0);   // clear+start: clear wins
        add(4'b0001, 2'b01, 0, 0, 1'b0);   // IDLE -> RUN

        // ---- reset block ----
        #3 reset_n = 1'b0;
        repeat (3) @(posedge clk_100MHz);
        #1;
        check_outputs_zero("reset");
        reset_n = 1'b1;
        repeat (10) tick();

        // ---- start, latency and tick rate ----
        press(4'b0001, 20);
        found = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (state == 2'b01) begin
                found = i;
                break;
            end
        end
        check("start_to_run", int'(found != 0), 1);
        found = 21;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (cnt_en) begin
                found = i;
                break;
            end
        end
        check("first_en_delay", found, 10);
        base_en = n_en;
        repeat (1000) tick();
        check("ticks_in_1000", n_en - base_en, 100);
        repeat (15) tick();

        // ---- table-driven vectors ----
        foreach (vecs[k]) begin
            base_clr  = n_clr;
            base_load = n_load;
            press(vecs[k].mask, 8);
            repeat (20) tick();
            check($sformatf("v%0d_state", k), int'(state), int'(vecs[k].exp_state));
            check($sformatf("v%0d_clr", k), n_clr - base_clr, vecs[k].exp_clr);
            check($sformatf("v%0d_load", k), n_load - base_load, vecs[k].exp_load);
            check($sformatf("v%0d_frz", k), int'(lap_freeze), int'(vecs[k].exp_freeze));
        end

        // ---- bouncing clear: exactly one event ----
        press(4'b0010, 8);
        repeat (20) tick();
        check("pause_before_bounce", int'(state), 2);
        base_clr = n_clr;
        press(4'b0100, 2);
        repeat (2) tick();
        repeat (2) tick();
        press(4'b0100, 50);
        repeat (62) tick();
        check("bounce_clr_count", n_clr - base_clr, 1);
        check("bounce_state", int'(state), 0);

        // ---- asynchronous reset mid-RUN ----
        press(4'b0001, 8);
        repeat (20) tick();
        check("run_before_reset", int'(state), 1);
        repeat (3) tick();
        reset_n = 1'b0;
        #2;
        check_outputs_zero("reset_mid_run");

        // ---- reset released while start is held ----
        press(4'b0001, 40);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (38) tick();
        repeat (12) tick();
        check("held_through_reset", int'(state), 0);
        press(4'b0001, 8);
        repeat (20) tick();
        check("press_after_release", int'(state), 1);
        repeat (30) tick();

        // ---- running invariants ----
        check("en_in_idle_pause", viol_idle, 0);
        check("en_period", gap_bad, 0);
        check("lap_outputs", viol_lap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
